// File: rtl/mb_rx_flit_fifo.sv
// Receive-side mainband flit FWFT FIFO between the lane demapper and the adapter consumer.
// Optional occupancy port o_level is enabled by defining MB_RX_FIFO_LEVEL_EN.
module mb_rx_flit_fifo #(
  parameter int DATA_W = 512,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_data_valid,
  input  logic [1:0]        i_functional_rx_lanes,
  input  logic              i_flush,
  output logic [DATA_W-1:0] o_flit,
  output logic              o_flit_valid,
  input  logic              i_flit_ready,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_overflow
`ifdef MB_RX_FIFO_LEVEL_EN
  ,
  output logic [ADDR_W:0]   o_level
`endif
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic              r_valid_q;
  logic              r_overflow;

  logic w_push_req;
  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  // 8-lane modes see valid held high across the demapper's accumulation, so only its rising edge counts.
  always_comb begin
    w_push_req = 1'b0;
    case (i_functional_rx_lanes)
      2'b11:        w_push_req = i_data_valid;
      2'b01, 2'b10: w_push_req = i_data_valid & ~r_valid_q;
      default:      w_push_req = 1'b0;
    endcase
  end

  assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                   (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_pop   = ~w_empty & i_flit_ready;
  assign w_push  = w_push_req & (~w_full | w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_valid_q  <= 1'b0;
      r_overflow <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_valid_q  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push_req && !w_push) begin
        r_overflow <= 1'b1;
      end
      r_valid_q <= (i_functional_rx_lanes == 2'b00) ? 1'b0 : i_data_valid;
    end
  end

  assign o_flit       = r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign o_flit_valid = ~w_empty;
  assign o_full       = w_full;
  assign o_empty      = w_empty;
  assign o_overflow   = r_overflow;

`ifdef MB_RX_FIFO_LEVEL_EN
  assign o_level = r_wr_ptr - r_rd_ptr;
`endif

endmodule

// File: tb/tb_mb_rx_flit_fifo.sv
// Scoreboard bench for mb_rx_flit_fifo: directed flits queued as expectations, a monitor checks pops.
module tb_mb_rx_flit_fifo;
  localparam int DATA_W = 512;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] data;
  logic              data_valid;
  logic [1:0]        mode;
  logic              flush;
  logic [DATA_W-1:0] flit;
  logic              flit_valid;
  logic              flit_ready;
  logic              full;
  logic              empty;
  logic              overflow;
`ifdef MB_RX_FIFO_LEVEL_EN
  logic [ADDR_W:0]   level;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [DATA_W-1:0] exp_q [$];

  always #5 clk = ~clk;

  mb_rx_flit_fifo #(.DATA_W(DATA_W), .DEPTH(4), .ADDR_W(ADDR_W)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_data(data),
    .i_data_valid(data_valid),
    .i_functional_rx_lanes(mode),
    .i_flush(flush),
    .o_flit(flit),
    .o_flit_valid(flit_valid),
    .i_flit_ready(flit_ready),
    .o_full(full),
    .o_empty(empty),
    .o_overflow(overflow)
`ifdef MB_RX_FIFO_LEVEL_EN
    ,
    .o_level(level)
`endif
  );

  function automatic logic [DATA_W-1:0] mk(input int id);
    logic [31:0] w;
    w = 32'hC0DE_0000 + id;
    return {16{w}};
  endfunction

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a pop happens at the next edge whenever valid and ready are both high mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && flit_valid === 1'b1 && flit_ready === 1'b1 && flush === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_pop: got %0h expected none", flit);
        end else begin
          chk("pop_data", flit, exp_q.pop_front());
          $display("pop flit %08h", flit[31:0]);
        end
      end
    end
  end

  task automatic push_one(input int id, input bit expect_it);
    data = mk(id);
    data_valid = 1'b1;
    if (expect_it) exp_q.push_back(mk(id));
    tick();
    $display("push flit %08h", data[31:0]);
  endtask

  task automatic drain(input int n);
    data_valid = 1'b0;
    flit_ready = 1'b1;
    repeat (n) tick();
    flit_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; data = '0; data_valid = 1'b0; mode = 2'b11; flush = 1'b0; flit_ready = 1'b0;
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_flit_valid", flit_valid, 0);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // T1: three pushes in 16-lane mode, then drain
    push_one(1, 1); push_one(2, 1); push_one(3, 1);
    data_valid = 1'b0;
    chk("t1_head", flit, mk(1));
    chk("t1_empty", empty, 0);
    chk("t1_full", full, 0);
`ifdef MB_RX_FIFO_LEVEL_EN
    chk("t1_level", level, 3);
`endif
    drain(3);
    chk("t1_empty_after", empty, 1);

    // T2: 8-lane mode, valid held high -> single entry
    mode = 2'b01;
    data = mk(10); data_valid = 1'b1; exp_q.push_back(mk(10));
    repeat (6) tick();
    chk("t2_one_head", flit, mk(10));
    chk("t2_not_empty", empty, 0);
    drain(1);
    chk("t2_only_one", empty, 1);
    data_valid = 1'b0; tick();
    mode = 2'b10;
    push_one(11, 1);
    data_valid = 1'b0;
    chk("t2_second", flit_valid, 1);
    drain(1);
    chk("t2_empty", empty, 1);

    // T3: overflow on fifth push
    mode = 2'b11;
    push_one(20, 1); push_one(21, 1); push_one(22, 1); push_one(23, 1);
    chk("t3_full", full, 1);
    chk("t3_no_ovf_yet", overflow, 0);
    push_one(24, 0);
    chk("t3_ovf", overflow, 1);
    chk("t3_still_full", full, 1);
    drain(4);
    chk("t3_empty", empty, 1);
    chk("t3_ovf_sticky", overflow, 1);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t3_flush_clears_ovf", overflow, 0);

    // T4: full with simultaneous pop and push
    push_one(30, 1); push_one(31, 1); push_one(32, 1); push_one(33, 1);
    flit_ready = 1'b1;
    push_one(34, 1);
    flit_ready = 1'b0; data_valid = 1'b0;
    chk("t4_no_ovf", overflow, 0);
    chk("t4_full", full, 1);
`ifdef MB_RX_FIFO_LEVEL_EN
    chk("t4_level", level, 4);
`endif
    drain(4);
    chk("t4_empty", empty, 1);

    // T5: flush beats a simultaneous push
    push_one(40, 0); push_one(41, 0);
    flush = 1'b1;
    push_one(42, 0);
    flush = 1'b0; data_valid = 1'b0;
    chk("t5_empty", empty, 1);
    chk("t5_flit_valid", flit_valid, 0);
    chk("t5_ovf", overflow, 0);
`ifdef MB_RX_FIFO_LEVEL_EN
    chk("t5_level", level, 0);
`endif
    push_one(43, 1);
    data_valid = 1'b0;
    chk("t5_after_flush_head", flit, mk(43));
    drain(1);

    // Mode 00 ignores valid
    mode = 2'b00;
    data = mk(50); data_valid = 1'b1;
    repeat (2) tick();
    data_valid = 1'b0;
    chk("m00_empty", empty, 1);

    // T6: async reset mid-stream
    mode = 2'b11;
    push_one(60, 0); push_one(61, 0); push_one(62, 0);
    data_valid = 1'b0;
    chk("t6_pre_flit_valid", flit_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_empty", empty, 1);
    chk("t6_rst_flit_valid", flit_valid, 0);
    chk("t6_rst_full", full, 0);
    tick();
    rst_n = 1'b1;
    tick();
    push_one(63, 1);
    data_valid = 1'b0;
    chk("t6_first_after_rst", flit, mk(63));
    chk("t6_valid_after_rst", flit_valid, 1);
    drain(1);

    repeat (3) tick();
    chk("scoreboard_drained", 512'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
